// File: rtl/cmac_mac_unit_param.sv
// Parametrised CMAC MAC cell: gated INT16 / dual-INT8 dot product of LANES pairs,
// optional multi-beat accumulation, and a fixed PIPE-cycle output pipeline.
module cmac_mac_unit_param #(
  parameter int LANES = 8,
  parameter int DW    = 16,
  parameter int PIPE  = 3,
  parameter int OW    = 2*DW + $clog2(LANES) + 1,
  parameter int ACC_W = 48
) (
  input  logic                  nvdla_core_clk,
  input  logic                  nvdla_core_rstn,
  input  logic                  cfg_reg_en,
  input  logic                  cfg_is_int8,
  input  logic                  cfg_acc_en,
  input  logic [LANES*DW-1:0]   dat_actv_data,
  input  logic [LANES-1:0]      dat_actv_nz,
  input  logic [LANES-1:0]      dat_actv_pvld,
  input  logic                  dat_actv_last,
  input  logic [LANES*DW-1:0]   wt_actv_data,
  input  logic [LANES-1:0]      wt_actv_nz,
  input  logic [LANES-1:0]      wt_actv_pvld,
  output logic [ACC_W-1:0]      mac_out_data,
  output logic                  mac_out_pvld
);

  localparam int HW = DW / 2;

  logic                 r_mode_int8;
  logic                 r_mode_acc;
  logic [ACC_W-1:0]     r_acc;
  logic                 r_vld [PIPE];
  logic [ACC_W-1:0]     r_dat [PIPE];

  logic                 w_op_vld;
  logic signed [OW-1:0] w_lane [LANES];
  logic signed [OW-1:0] w_sum;
  logic [ACC_W-1:0]     w_sum_ext;
  logic [ACC_W-1:0]     w_acc_sum;
  logic                 w_s0_vld;

  assign w_op_vld = dat_actv_pvld[0] & wt_actv_pvld[0];

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic                   w_g;
    logic signed [DW-1:0]   w_a;
    logic signed [DW-1:0]   w_b;
    logic signed [HW-1:0]   w_alo, w_ahi, w_blo, w_bhi;
    logic signed [2*DW-1:0] w_p16;
    logic signed [DW-1:0]   w_plo, w_phi;

    assign w_g = dat_actv_pvld[gi] & wt_actv_pvld[gi] & dat_actv_nz[gi] & wt_actv_nz[gi];
    // Gate the operands themselves so a disabled lane cannot leak X into the sum.
    assign w_a   = w_g ? dat_actv_data[gi*DW +: DW] : '0;
    assign w_b   = w_g ? wt_actv_data[gi*DW +: DW]  : '0;
    assign w_alo = w_a[HW-1:0];
    assign w_ahi = w_a[DW-1:HW];
    assign w_blo = w_b[HW-1:0];
    assign w_bhi = w_b[DW-1:HW];
    assign w_p16 = w_a * w_b;
    assign w_plo = w_alo * w_blo;
    assign w_phi = w_ahi * w_bhi;
    assign w_lane[gi] = r_mode_int8
                        ? ({{(OW-DW){w_plo[DW-1]}}, w_plo} + {{(OW-DW){w_phi[DW-1]}}, w_phi})
                        : {{(OW-2*DW){w_p16[2*DW-1]}}, w_p16};
  end

  // Adder tree over all lane contributions.
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      w_sum = w_sum + w_lane[i];
    end
  end

  if (ACC_W > OW) begin : g_ext
    assign w_sum_ext = {{(ACC_W-OW){w_sum[OW-1]}}, w_sum};
  end else begin : g_noext
    assign w_sum_ext = w_sum;
  end

  assign w_acc_sum = r_acc + w_sum_ext;
  assign w_s0_vld  = w_op_vld & (~r_mode_acc | dat_actv_last);

  // Mode registers and running accumulator.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_mode_int8 <= 1'b0;
      r_mode_acc  <= 1'b0;
      r_acc       <= '0;
    end else begin
      if (cfg_reg_en) begin
        r_mode_int8 <= cfg_is_int8;
        r_mode_acc  <= cfg_acc_en;
      end
      if (cfg_reg_en && !cfg_acc_en) begin
        r_acc <= '0;
      end else if (r_mode_acc && w_op_vld) begin
        r_acc <= dat_actv_last ? '0 : w_acc_sum;
      end
    end
  end

  // Output pipeline; data stages load only alongside a valid.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      for (int k = 0; k < PIPE; k++) begin
        r_vld[k] <= 1'b0;
        r_dat[k] <= '0;
      end
    end else begin
      r_vld[0] <= w_s0_vld;
      if (w_s0_vld) begin
        r_dat[0] <= r_mode_acc ? w_acc_sum : w_sum_ext;
      end
      for (int k = 1; k < PIPE; k++) begin
        r_vld[k] <= r_vld[k-1];
        if (r_vld[k-1]) begin
          r_dat[k] <= r_dat[k-1];
        end
      end
    end
  end

  assign mac_out_pvld = r_vld[PIPE-1];
  assign mac_out_data = r_dat[PIPE-1];

endmodule

// File: tb/tb_cmac_mac_unit_param.sv
// Randomised and directed bench for cmac_mac_unit_param against an arithmetic
// reference model (dot product, accumulation and PIPE-cycle latency).
module tb_cmac_mac_unit_param;

  localparam int L  = 8;
  localparam int D  = 16;
  localparam int P  = 3;
  localparam int AW = 48;

  typedef struct packed {
    logic [L*D-1:0] d;
    logic [L*D-1:0] w;
    logic [L-1:0]   dnz;
    logic [L-1:0]   wnz;
    logic [L-1:0]   dpv;
    logic [L-1:0]   wpv;
    logic           last;
  } beat_t;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              cfg_reg_en = 1'b0, cfg_is_int8 = 1'b0, cfg_acc_en = 1'b0;
  logic [L*D-1:0]    dat_actv_data = '0, wt_actv_data = '0;
  logic [L-1:0]      dat_actv_nz = '0, dat_actv_pvld = '0, wt_actv_nz = '0, wt_actv_pvld = '0;
  logic              dat_actv_last = 1'b0;
  logic [AW-1:0]     mac_out_data;
  logic              mac_out_pvld;

  int errors = 0;
  int checks = 0;

  bit            m_int8 = 1'b0;
  bit            m_acc  = 1'b0;
  logic [AW-1:0] m_accum = '0;
  logic [AW-1:0] last_out = '0;
  beat_t         q[$];

  cmac_mac_unit_param #(.LANES(L), .DW(D), .PIPE(P), .ACC_W(AW)) dut (
    .nvdla_core_clk(clk), .nvdla_core_rstn(rstn),
    .cfg_reg_en(cfg_reg_en), .cfg_is_int8(cfg_is_int8), .cfg_acc_en(cfg_acc_en),
    .dat_actv_data(dat_actv_data), .dat_actv_nz(dat_actv_nz),
    .dat_actv_pvld(dat_actv_pvld), .dat_actv_last(dat_actv_last),
    .wt_actv_data(wt_actv_data), .wt_actv_nz(wt_actv_nz), .wt_actv_pvld(wt_actv_pvld),
    .mac_out_data(mac_out_data), .mac_out_pvld(mac_out_pvld)
  );

  always #5 clk = ~clk;

  // Plain signed arithmetic over the gated lanes.
  function automatic longint beat_sum(beat_t b, bit i8);
    longint s = 0;
    for (int i = 0; i < L; i++) begin
      if (b.dpv[i] && b.wpv[i] && b.dnz[i] && b.wnz[i]) begin
        logic [15:0] a;
        logic [15:0] w;
        a = b.d[i*D +: D];
        w = b.w[i*D +: D];
        if (i8)
          s += longint'($signed(a[7:0])) * longint'($signed(w[7:0]))
             + longint'($signed(a[15:8])) * longint'($signed(w[15:8]));
        else
          s += longint'($signed(a)) * longint'($signed(w));
      end
    end
    return s;
  endfunction

  function automatic beat_t mk_uniform(logic [15:0] dv, logic [15:0] wv);
    beat_t b;
    for (int i = 0; i < L; i++) begin
      b.d[i*D +: D] = dv;
      b.w[i*D +: D] = wv;
    end
    b.dnz = '1; b.wnz = '1; b.dpv = '1; b.wpv = '1; b.last = 1'b0;
    return b;
  endfunction

  function automatic beat_t mk_single(logic [15:0] dv, logic [15:0] wv, logic lst);
    beat_t b;
    b = mk_uniform(dv, wv);
    b.dnz = 8'h01;
    b.last = lst;
    return b;
  endfunction

  function automatic beat_t mk_random();
    beat_t b;
    for (int i = 0; i < L; i++) begin
      b.d[i*D +: D] = 16'($urandom);
      b.w[i*D +: D] = 16'($urandom);
      b.dnz[i] = ($urandom_range(0, 9) != 0);
      b.wnz[i] = ($urandom_range(0, 9) != 0);
      b.dpv[i] = ($urandom_range(0, 7) != 0);
      b.wpv[i] = ($urandom_range(0, 7) != 0);
    end
    b.last = ($urandom_range(0, 2) == 0);
    return b;
  endfunction

  task automatic drive_idle();
    dat_actv_data = '0; wt_actv_data = '0;
    dat_actv_nz = '0; wt_actv_nz = '0;
    dat_actv_pvld = '0; wt_actv_pvld = '0;
    dat_actv_last = 1'b0;
  endtask

  task automatic set_mode(bit i8, bit acc);
    cfg_reg_en = 1'b1; cfg_is_int8 = i8; cfg_acc_en = acc;
    @(posedge clk); #1;
    cfg_reg_en = 1'b0;
    m_int8 = i8;
    m_acc  = acc;
    if (!acc) m_accum = '0;
  endtask

  // Play the queued beats one per cycle and check every output cycle.
  task automatic run_stream(string name);
    logic          ev [0:255];
    logic [AW-1:0] ed [0:255];
    int            n;
    n = q.size();
    for (int i = 0; i < 256; i++) begin
      ev[i] = 1'b0;
      ed[i] = '0;
    end
    for (int c = 0; c < n + P + 2; c++) begin
      @(posedge clk); #1;
      checks++;
      if (mac_out_pvld !== ev[c]) begin
        errors++;
        $display("FAIL %s pvld cycle %0d: got %b want %b", name, c, mac_out_pvld, ev[c]);
      end
      checks++;
      if (ev[c]) begin
        if (mac_out_data !== ed[c]) begin
          errors++;
          $display("FAIL %s data cycle %0d: got %h want %h", name, c, mac_out_data, ed[c]);
        end
        last_out = ed[c];
      end else if (mac_out_data !== last_out) begin
        errors++;
        $display("FAIL %s hold cycle %0d: got %h want %h", name, c, mac_out_data, last_out);
      end
      if (c < n) begin
        beat_t  b;
        longint s;
        b = q[c];
        dat_actv_data = b.d; wt_actv_data = b.w;
        dat_actv_nz = b.dnz; wt_actv_nz = b.wnz;
        dat_actv_pvld = b.dpv; wt_actv_pvld = b.wpv;
        dat_actv_last = b.last;
        if (b.dpv[0] && b.wpv[0]) begin
          s = beat_sum(b, m_int8);
          if (!m_acc) begin
            ev[c+P] = 1'b1;
            ed[c+P] = s[AW-1:0];
          end else begin
            m_accum = m_accum + s[AW-1:0];
            if (b.last) begin
              ev[c+P] = 1'b1;
              ed[c+P] = m_accum;
              m_accum = '0;
            end
          end
        end
      end else begin
        drive_idle();
      end
    end
    q.delete();
  endtask

  task automatic test_reset();
    drive_idle();
    #12;
    checks++;
    if (mac_out_pvld !== 1'b0 || mac_out_data !== '0) begin
      errors++;
      $display("FAIL reset_hold: got pvld=%b data=%h want 0/0", mac_out_pvld, mac_out_data);
    end
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (mac_out_pvld !== 1'b0 || mac_out_data !== '0) begin
      errors++;
      $display("FAIL reset_release: got pvld=%b data=%h want 0/0", mac_out_pvld, mac_out_data);
    end
  endtask

  task automatic test_int16_extremes();
    q.push_back(mk_uniform(16'h7FFF, 16'h7FFF));
    q.push_back(mk_uniform(16'h0000, 16'h0000));
    q.push_back(mk_uniform(16'h8000, 16'h8000));
    run_stream("int16_extremes");
  endtask

  task automatic test_gating();
    beat_t b;
    b = mk_uniform(16'd1, 16'd1);
    b.d[3*D +: D] = 16'd100; b.w[3*D +: D] = 16'd100; b.dnz[3] = 1'b0;
    q.push_back(b);
    b = mk_uniform(16'd1, 16'd1);
    b.d[3*D +: D] = 16'd100; b.w[3*D +: D] = 16'd100; b.dnz[3] = 1'b0;
    b.wpv[5] = 1'b0; b.d[5*D +: D] = 'x; b.w[5*D +: D] = 'x;
    q.push_back(b);
    run_stream("gating");
  endtask

  task automatic test_int8();
    set_mode(1'b1, 1'b0);
    q.push_back(mk_uniform(16'h8080, 16'h8080));
    q.push_back(mk_uniform(16'h02FF, 16'h0301));
    for (int i = 0; i < 20; i++) q.push_back(mk_random());
    run_stream("int8");
    set_mode(1'b0, 1'b0);
  endtask

  task automatic test_accumulate();
    beat_t b;
    set_mode(1'b0, 1'b1);
    for (int g = 0; g < 2; g++) begin
      for (int i = 0; i < 4; i++) begin
        b = mk_uniform(16'd1, 16'd5);
        b.dnz = 8'h03;
        b.last = (i == 3);
        q.push_back(b);
      end
    end
    for (int i = 0; i < 24; i++) q.push_back(mk_random());
    q.push_back(mk_single(16'd3, 16'd3, 1'b1));
    run_stream("accumulate");
    set_mode(1'b1, 1'b1);
    for (int i = 0; i < 16; i++) q.push_back(mk_random());
    q.push_back(mk_single(16'd2, 16'd2, 1'b1));
    run_stream("accumulate_int8");
    set_mode(1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int k = 1; k <= 5; k++) q.push_back(mk_single(16'(k), 16'd1, 1'b0));
    run_stream("back_to_back");
  endtask

  task automatic test_random_int16();
    for (int i = 0; i < 40; i++) q.push_back(mk_random());
    run_stream("random_int16");
  endtask

  task automatic test_reset_midflight();
    beat_t b;
    set_mode(1'b1, 1'b1);
    b = mk_uniform(16'h0102, 16'h0304);
    b.last = 1'b1;
    dat_actv_data = b.d; wt_actv_data = b.w;
    dat_actv_nz = b.dnz; wt_actv_nz = b.wnz;
    dat_actv_pvld = b.dpv; wt_actv_pvld = b.wpv;
    dat_actv_last = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    drive_idle();
    #1 rstn = 1'b0;
    #1;
    checks++;
    if (mac_out_pvld !== 1'b0 || mac_out_data !== '0) begin
      errors++;
      $display("FAIL midflight_reset: got pvld=%b data=%h want 0/0", mac_out_pvld, mac_out_data);
    end
    m_int8 = 1'b0; m_acc = 1'b0; m_accum = '0; last_out = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rstn = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      checks++;
      if (mac_out_pvld !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_quiet cycle %0d: got pvld=%b want 0", c, mac_out_pvld);
      end
    end
    q.push_back(mk_uniform(16'h02FF, 16'h0301));
    run_stream("post_reset_mode");
  endtask

  initial begin
    test_reset();
    test_int16_extremes();
    test_gating();
    test_int8();
    test_accumulate();
    test_back_to_back();
    test_random_int16();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
